// File: rtl/ysyx_041461_pipe_ctrl.sv
// ysyx_041461_pipe_ctrl: pipeline sequencer.
// Stage valids, enables, flushes, PC select and trap drain/vector FSM.
module ysyx_041461_pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       IF_ready,
    input  logic       IF2_ready,
    input  logic       MEM_ready,
    input  logic       CD_ID_conflict,
    input  logic       CD_EXE_conflict,
    input  logic       CD_MEM_conflict,
    input  logic       CD_IF_trap,
    input  logic       CD_IF2_trap,
    input  logic       CD_ID_trap,
    input  logic       CD_EXE_trap,
    input  logic       CD_MEM_trap,
    input  logic       ID_jump,
    input  logic       WB_trap,
    output logic       IF2_valid,
    output logic       ID_valid,
    output logic       EXE_valid,
    output logic       MEM_valid,
    output logic       WB_valid,
    output logic       IF_en,
    output logic       IF2_en,
    output logic       ID_en,
    output logic       EXE_en,
    output logic       MEM_en,
    output logic [1:0] PC_sel,
    output logic       trap_commit
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic if2_stall, id_stall, exe_stall;
    logic mem_hold, exe_hold, id_hold, if2_hold, if_hold;
    logic jump_acc;

    // Hold chain: a stall in any stage freezes every stage upstream of it.
    always_comb begin
        if2_stall = IF2_valid & ~IF2_ready;
        id_stall  = ID_valid & CD_ID_conflict;
        exe_stall = EXE_valid & CD_EXE_conflict;
        mem_hold  = MEM_valid & (~MEM_ready | CD_MEM_conflict);
        exe_hold  = mem_hold | exe_stall;
        id_hold   = exe_hold | id_stall;
        if2_hold  = id_hold | if2_stall;
        if_hold   = if2_hold | ~IF_ready;
        IF2_en    = ~if2_hold;
        ID_en     = ~id_hold;
        EXE_en    = ~exe_hold;
        MEM_en    = ~mem_hold;
        jump_acc  = ID_jump & ID_valid & ~id_hold & ~CD_ID_trap
                  & (state != VECTOR);
    end

    // Trap FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Trap FSM next state, IF enable, PC source and commit pulse.
    always_comb begin
        state_nxt   = state;
        IF_en       = 1'b0;
        PC_sel      = 2'd0;
        trap_commit = 1'b0;
        unique case (state)
            RUN: begin
                IF_en = ~if_hold & ~CD_IF_trap;
                if (jump_acc) PC_sel = 2'd1;
                if (CD_IF_trap) state_nxt = DRAIN;
            end
            DRAIN: begin
                trap_commit = WB_valid & WB_trap;
                if (jump_acc) PC_sel = 2'd1;
                if (trap_commit)      state_nxt = VECTOR;
                else if (~CD_IF_trap) state_nxt = RUN;
            end
            VECTOR: begin
                PC_sel    = 2'd2;
                IF_en     = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Stage valids: kill beats jump flush beats hold beats normal advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            IF2_valid <= 1'b0;
            ID_valid  <= 1'b0;
            EXE_valid <= 1'b0;
            MEM_valid <= 1'b0;
            WB_valid  <= 1'b0;
        end else if (state == VECTOR) begin
            IF2_valid <= 1'b0;
            ID_valid  <= 1'b0;
            EXE_valid <= 1'b0;
            MEM_valid <= 1'b0;
            WB_valid  <= 1'b0;
        end else begin
            if (CD_IF2_trap)   IF2_valid <= 1'b0;
            else if (jump_acc) IF2_valid <= 1'b0;
            else if (!if2_hold) IF2_valid <= IF_ready & IF_en;

            if (CD_ID_trap)    ID_valid <= 1'b0;
            else if (jump_acc) ID_valid <= 1'b0;
            else if (!id_hold) ID_valid <= IF2_valid & ~if2_stall & ~CD_IF2_trap;

            if (CD_EXE_trap)    EXE_valid <= 1'b0;
            else if (!exe_hold) EXE_valid <= ID_valid & ~id_stall & ~CD_ID_trap;

            if (CD_MEM_trap && MEM_ready) MEM_valid <= 1'b0;
            else if (!mem_hold) MEM_valid <= EXE_valid & ~exe_stall & ~CD_EXE_trap;

            WB_valid <= MEM_valid & ~mem_hold & ~CD_MEM_trap;
        end
    end

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// tb_ysyx_041461_pipe_ctrl: directed bench for the pipeline sequencer.
// Valids packed as {IF2,ID,EXE,MEM,WB}; enables as {IF,IF2,ID,EXE,MEM}.
module tb_ysyx_041461_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       IF_ready, IF2_ready, MEM_ready;
    logic       CD_ID_conflict, CD_EXE_conflict, CD_MEM_conflict;
    logic       CD_IF_trap, CD_IF2_trap, CD_ID_trap, CD_EXE_trap, CD_MEM_trap;
    logic       ID_jump, WB_trap;
    logic       IF2_valid, ID_valid, EXE_valid, MEM_valid, WB_valid;
    logic       IF_en, IF2_en, ID_en, EXE_en, MEM_en;
    logic [1:0] PC_sel;
    logic       trap_commit;

    int ncmp = 0;
    int nerr = 0;

    wire [4:0] vals = {IF2_valid, ID_valid, EXE_valid, MEM_valid, WB_valid};
    wire [4:0] ens  = {IF_en, IF2_en, ID_en, EXE_en, MEM_en};

    always #5 clk = ~clk;

    ysyx_041461_pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .IF_ready(IF_ready), .IF2_ready(IF2_ready), .MEM_ready(MEM_ready),
        .CD_ID_conflict(CD_ID_conflict), .CD_EXE_conflict(CD_EXE_conflict),
        .CD_MEM_conflict(CD_MEM_conflict),
        .CD_IF_trap(CD_IF_trap), .CD_IF2_trap(CD_IF2_trap),
        .CD_ID_trap(CD_ID_trap), .CD_EXE_trap(CD_EXE_trap),
        .CD_MEM_trap(CD_MEM_trap),
        .ID_jump(ID_jump), .WB_trap(WB_trap),
        .IF2_valid(IF2_valid), .ID_valid(ID_valid), .EXE_valid(EXE_valid),
        .MEM_valid(MEM_valid), .WB_valid(WB_valid),
        .IF_en(IF_en), .IF2_en(IF2_en), .ID_en(ID_en),
        .EXE_en(EXE_en), .MEM_en(MEM_en),
        .PC_sel(PC_sel), .trap_commit(trap_commit)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        IF_ready = 1; IF2_ready = 1; MEM_ready = 1;
        CD_ID_conflict = 0; CD_EXE_conflict = 0; CD_MEM_conflict = 0;
        CD_IF_trap = 0; CD_IF2_trap = 0; CD_ID_trap = 0;
        CD_EXE_trap = 0; CD_MEM_trap = 0;
        ID_jump = 0; WB_trap = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        idle_inputs();
        #2;
        ncmp++;
        if (vals !== 5'b00000) begin
            nerr++; $display("FAIL reset_valids got %b want %b", vals, 5'b00000);
        end
        ncmp++;
        if (PC_sel !== 2'd0 || trap_commit !== 1'b0) begin
            nerr++;
            $display("FAIL reset_pcsel_commit got %0d/%b want 0/0", PC_sel, trap_commit);
        end
        ncmp++;
        if (ens !== 5'b11111) begin
            nerr++; $display("FAIL reset_enables got %b want %b", ens, 5'b11111);
        end
        step();
        rst = 0;
    endtask

    task automatic test_fill;
        logic [4:0] exp_v [5];
        exp_v = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};
        for (int i = 0; i < 5; i++) begin
            step();
            ncmp++;
            if (vals !== exp_v[i]) begin
                nerr++;
                $display("FAIL fill_edge%0d valids got %b want %b", i + 1, vals, exp_v[i]);
            end
            ncmp++;
            if (ens !== 5'b11111) begin
                nerr++;
                $display("FAIL fill_edge%0d enables got %b want %b", i + 1, ens, 5'b11111);
            end
        end
    endtask

    task automatic test_id_conflict;
        logic [4:0] exp_v [5];
        exp_v = '{5'b11011, 5'b11001, 5'b11100, 5'b11110, 5'b11111};
        CD_ID_conflict = 1;
        for (int i = 0; i < 5; i++) begin
            if (i < 2) begin
                #1;
                ncmp++;
                if (ens !== 5'b00011) begin
                    nerr++;
                    $display("FAIL idc_en%0d enables got %b want %b", i, ens, 5'b00011);
                end
            end
            step();
            if (i == 1) CD_ID_conflict = 0;
            ncmp++;
            if (vals !== exp_v[i]) begin
                nerr++;
                $display("FAIL idc_edge%0d valids got %b want %b", i + 1, vals, exp_v[i]);
            end
        end
    endtask

    task automatic test_mem_stall;
        MEM_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            ncmp++;
            if (ens !== 5'b00000) begin
                nerr++; $display("FAIL mstall_en%0d enables got %b want %b", i, ens, 5'b00000);
            end
            step();
            ncmp++;
            if (vals !== 5'b11110) begin
                nerr++;
                $display("FAIL mstall_edge%0d valids got %b want %b", i + 1, vals, 5'b11110);
            end
        end
        MEM_ready = 1;
        step();
        ncmp++;
        if (vals !== 5'b11111) begin
            nerr++; $display("FAIL mstall_release valids got %b want %b", vals, 5'b11111);
        end
    endtask

    task automatic test_jump;
        logic [4:0] exp_v [6];
        exp_v = '{5'b00111, 5'b10011, 5'b11001, 5'b11100, 5'b11110, 5'b11111};
        ID_jump = 1;
        #1;
        ncmp++;
        if (PC_sel !== 2'd1) begin
            nerr++; $display("FAIL jump_pcsel got %0d want 1", PC_sel);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            ID_jump = 0;
            ncmp++;
            if (vals !== exp_v[i]) begin
                nerr++;
                $display("FAIL jump_edge%0d valids got %b want %b", i + 1, vals, exp_v[i]);
            end
        end
        #1;
        ncmp++;
        if (PC_sel !== 2'd0) begin
            nerr++; $display("FAIL jump_pcsel_after got %0d want 0", PC_sel);
        end
    endtask

    task automatic test_mem_kill;
        CD_MEM_trap = 1;
        MEM_ready = 0;
        step();
        ncmp++;
        if (vals !== 5'b11110) begin
            nerr++; $display("FAIL mkill_wait valids got %b want %b", vals, 5'b11110);
        end
        MEM_ready = 1;
        step();
        CD_MEM_trap = 0;
        ncmp++;
        if (vals !== 5'b11100) begin
            nerr++; $display("FAIL mkill_done valids got %b want %b", vals, 5'b11100);
        end
        step();
        step();
        ncmp++;
        if (vals !== 5'b11111) begin
            nerr++; $display("FAIL mkill_refill valids got %b want %b", vals, 5'b11111);
        end
    endtask

    task automatic test_trap;
        CD_IF_trap = 1; CD_IF2_trap = 1; CD_ID_trap = 1;
        #1;
        ncmp++;
        if (IF_en !== 1'b0) begin
            nerr++; $display("FAIL trap_run_ifen got %b want 0", IF_en);
        end
        step();
        ncmp++;
        if (vals !== 5'b00011) begin
            nerr++; $display("FAIL trap_e1 valids got %b want %b", vals, 5'b00011);
        end
        #1;
        ncmp++;
        if (IF_en !== 1'b0 || trap_commit !== 1'b0) begin
            nerr++;
            $display("FAIL trap_drain got ifen=%b commit=%b want 0/0", IF_en, trap_commit);
        end
        step();
        ncmp++;
        if (vals !== 5'b00001) begin
            nerr++; $display("FAIL trap_e2 valids got %b want %b", vals, 5'b00001);
        end
        WB_trap = 1;
        #1;
        ncmp++;
        if (trap_commit !== 1'b1 || PC_sel !== 2'd0) begin
            nerr++;
            $display("FAIL trap_commit got %b/%0d want 1/0", trap_commit, PC_sel);
        end
        step();
        WB_trap = 0; CD_IF_trap = 0; CD_IF2_trap = 0; CD_ID_trap = 0;
        ID_jump = 1;
        #1;
        ncmp++;
        if (PC_sel !== 2'd2 || IF_en !== 1'b1 || trap_commit !== 1'b0) begin
            nerr++;
            $display("FAIL trap_vector got pcsel=%0d ifen=%b commit=%b want 2/1/0",
                     PC_sel, IF_en, trap_commit);
        end
        step();
        ID_jump = 0;
        ncmp++;
        if (vals !== 5'b00000) begin
            nerr++; $display("FAIL trap_flush valids got %b want %b", vals, 5'b00000);
        end
        #1;
        ncmp++;
        if (IF_en !== 1'b1 || PC_sel !== 2'd0) begin
            nerr++; $display("FAIL trap_back_run got ifen=%b pcsel=%0d want 1/0", IF_en, PC_sel);
        end
        step();
        ncmp++;
        if (vals !== 5'b10000) begin
            nerr++; $display("FAIL trap_vec_fetch valids got %b want %b", vals, 5'b10000);
        end
        repeat (4) step();
    endtask

    task automatic test_rst_async;
        CD_IF_trap = 1;
        IF2_ready = 0;
        step();
        IF2_ready = 1;
        ncmp++;
        if (vals !== 5'b10111) begin
            nerr++; $display("FAIL arst_pre valids got %b want %b", vals, 5'b10111);
        end
        WB_trap = 1;
        #1;
        ncmp++;
        if (trap_commit !== 1'b1) begin
            nerr++; $display("FAIL arst_pre_commit got %b want 1", trap_commit);
        end
        #1;
        rst = 1;
        #1;
        ncmp++;
        if (vals !== 5'b00000 || trap_commit !== 1'b0) begin
            nerr++;
            $display("FAIL arst_clear got valids=%b commit=%b want 00000/0", vals, trap_commit);
        end
        rst = 0;
        CD_IF_trap = 0;
        WB_trap = 0;
        #1;
        ncmp++;
        if (IF_en !== 1'b1 || PC_sel !== 2'd0) begin
            nerr++; $display("FAIL arst_state got ifen=%b pcsel=%0d want 1/0", IF_en, PC_sel);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_id_conflict();
        test_mem_stall();
        test_jump();
        test_mem_kill();
        test_trap();
        test_rst_async();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
